fifo_w32_stream_reader: RTL and testbench

//  Read-side consumer for the team's ap_fifo-style FIFOs (if_empty_n/if_read/if_dout, show-ahead data).
//  - Drains the FIFO into a valid/ready output stream through a 2-entry skid buffer.
//  - Marks packet boundaries with a tlast flag every PKT_LEN words.
//  - Sits between a FIFO (e.g. 32-bit, depth 5) and a downstream dataflow stage that may stall.

---
 rtl/fifo_w32_stream_reader.sv | 145 ++++++++++++++
 tb/tb_fifo_w32_stream_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_w32_stream_reader.sv
// Read-side consumer for an ap_fifo-style show-ahead FIFO. It drains the FIFO
// into a valid/ready stream through a two-entry skid buffer, and it tags every
// PKT_LEN-th word with m_tlast.
// Optional feature: define FIFO_RD_STATS_EN to add the word_cnt output, which
// counts output handshakes.
module fifo_w32_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PKT_LEN    = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_empty_n,
  output logic                  if_read_ce,
  output logic                  if_read,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  pkt_done
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

  localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(PKT_LEN - 1);

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  push, pop, new_last;

  // The FIFO read depends only on registered occupancy, never on m_tready.
  always_comb begin
    push     = if_empty_n & (occ_q != StTwo) & ~reset;
    pop      = (occ_q != StEmpty) & m_tready;
    new_last = (beat_q == LastBeat);
  end

  assign if_read_ce = ~reset;
  assign if_read    = push;
  assign m_tvalid   = (occ_q != StEmpty);
  assign m_tdata    = head_data_q;
  assign m_tlast    = head_last_q;
  assign pkt_done   = pkt_done_q;

  // Next state for the occupancy FSM, the two buffer entries, and the beat index.
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    beat_d      = beat_q;
    pkt_done_d  = pop & head_last_q;

    if (push) begin
      beat_d = new_last ? '0 : beat_q + CNT_WIDTH'(1);
    end

    unique case (occ_q)
      StEmpty: begin
        if (push) begin
          occ_d       = StOne;
          head_data_d = if_dout;
          head_last_d = new_last;
        end
      end
      StOne: begin
        if (push && pop) begin
          // The head leaves while the new word takes its place.
          head_data_d = if_dout;
          head_last_d = new_last;
        end else if (push) begin
          occ_d       = StTwo;
          skid_data_d = if_dout;
          skid_last_d = new_last;
        end else if (pop) begin
          occ_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          occ_d       = StOne;
          head_data_d = skid_data_q;
          head_last_d = skid_last_q;
        end
      end
      default: occ_d = StEmpty;
    endcase
  end

  // State registers with synchronous reset; buffered words are dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= StEmpty;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      beat_q      <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      beat_q      <= beat_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  // Count output handshakes; the count wraps naturally at 2^CNT_WIDTH.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (pop) begin
      word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Handshake counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_w32_stream_reader.sv
// Bench for fifo_w32_stream_reader. A queue-based model tracks the FIFO contents,
// the words in flight, and the packet position, and it is compared against the
// DUT on every cycle. A second instance with PKT_LEN=1 covers the single-word
// packet case.
module tb_fifo_w32_stream_reader;
  localparam int DW = 32;
  localparam int PL = 5;
`ifdef FIFO_RD_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, if_empty_n, if_read_ce, if_read, m_tvalid, m_tready, m_tlast, pkt_done;
  logic [DW-1:0] if_dout, m_tdata;
  logic          e1, ce1, rd1, v1, l1, pd1;
  logic [DW-1:0] d1, td1;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] word_cnt, wc1;
`endif

  fifo_w32_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_empty_n (if_empty_n),
    .if_read_ce (if_read_ce),
    .if_read    (if_read),
    .if_dout    (if_dout),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .pkt_done   (pkt_done)
`ifdef FIFO_RD_STATS_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  fifo_w32_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1), .CNT_WIDTH(CW)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .if_empty_n (e1),
    .if_read_ce (ce1),
    .if_read    (rd1),
    .if_dout    (d1),
    .m_tvalid   (v1),
    .m_tready   (1'b1),
    .m_tdata    (td1),
    .m_tlast    (l1),
    .pkt_done   (pd1)
`ifdef FIFO_RD_STATS_EN
    ,
    .word_cnt   (wc1)
`endif
  );

  int            checks = 0;
  int            failures = 0;
  bit            rst_r = 1'b1, rdy_r = 1'b0, avail_r = 1'b0;
  logic [DW-1:0] src[$];
  ent_t          exp_q[$];
  ent_t          log_q[$];
  int            pop_cyc[$];
  int            inflight = 0, in_count = 0, cyc = 0, reads_n = 0, wc_m = 0;
  bit            pd_exp = 1'b0, stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            n1_left = 0, last1_n = 0, pd1_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, compare outputs against
  // the model, advance the model, then let the rising edge happen.
  task automatic step();
    bit   exp_read, exp_pop;
    ent_t e;
    @(negedge clk);
    reset      = rst_r;
    m_tready   = rdy_r;
    if_empty_n = avail_r && (src.size() > 0);
    if_dout    = (src.size() > 0) ? src[0] : '0;
    e1         = (n1_left > 0);
    d1         = 32'hB0 + 32'(3 - n1_left);
    #1;
    exp_read = !rst_r && if_empty_n && (inflight < 2);
    exp_pop  = (inflight > 0) && rdy_r;
    check("if_read", {63'd0, if_read}, {63'd0, exp_read});
    check("if_read_ce", {63'd0, if_read_ce}, {63'd0, !rst_r});
    check("m_tvalid", {63'd0, m_tvalid}, {63'd0, inflight > 0});
    check("pkt_done", {63'd0, pkt_done}, {63'd0, pd_exp});
    if (inflight > 0) begin
      check("m_tdata", {32'd0, m_tdata}, {32'd0, exp_q[0].data});
      check("m_tlast", {63'd0, m_tlast}, {63'd0, exp_q[0].last});
    end
    if (stall_prev) check("stall_hold", {32'd0, m_tdata}, {32'd0, prev_data});
`ifdef FIFO_RD_STATS_EN
    check("word_cnt", 64'(word_cnt), 64'(wc_m));
`endif
    if (v1 && l1) last1_n++;
    if (pd1) pd1_n++;
    if (rd1) n1_left--;

    stall_prev = !rst_r && (inflight > 0) && !rdy_r;
    prev_data  = m_tdata;
    if (rst_r) begin
      exp_q.delete();
      inflight = 0;
      in_count = 0;
      pd_exp   = 1'b0;
      wc_m     = 0;
    end else begin
      pd_exp = exp_pop && exp_q[0].last;
      if (exp_pop) begin
        log_q.push_back(exp_q.pop_front());
        pop_cyc.push_back(cyc);
        inflight--;
        wc_m = (wc_m + 1) % (1 << CW);
      end
      if (exp_read) begin
        e.last = (in_count == PL - 1);
        e.data = src.pop_front();
        exp_q.push_back(e);
        inflight++;
        in_count = (in_count + 1) % PL;
        reads_n++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, 64'(log_q.size()), 64'(n));
  endtask

  initial begin
    int r0, lasts;
    reset = 1'b1; m_tready = 1'b0; if_empty_n = 1'b0; if_dout = '0; e1 = 1'b0; d1 = '0;

    // Reset state
    rst_r = 1'b1;
    repeat (3) step();
    check("rst_if_read_ce", {63'd0, if_read_ce}, 64'd0);
    check("rst_if_read", {63'd0, if_read}, 64'd0);
    rst_r = 1'b0;
    step();
    check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
    check("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
    check("rst_pkt_done", {63'd0, pkt_done}, 64'd0);

    // Streaming A0..A9 with m_tready held high
    for (int i = 0; i < 10; i++) src.push_back(32'hA0 + 32'(i));
    rdy_r = 1'b1; avail_r = 1'b1;
    log_q.delete(); pop_cyc.delete();
    run_until(10, 40, "t1_count");
    step();
    check("t1_beat0", 64'(log_q[0]), {31'd0, 1'b0, 32'hA0});
    check("t1_beat3", 64'(log_q[3]), {31'd0, 1'b0, 32'hA3});
    check("t1_beat4", 64'(log_q[4]), {31'd0, 1'b1, 32'hA4});
    check("t1_beat9", 64'(log_q[9]), {31'd0, 1'b1, 32'hA9});
    check("t1_span", 64'(pop_cyc[9] - pop_cyc[0]), 64'd9);

    // Stall: exactly two words are read, then reading stops
    rdy_r = 1'b0;
    for (int i = 0; i < 6; i++) src.push_back(32'hD0 + 32'(i));
    log_q.delete();
    r0 = reads_n;
    repeat (6) step();
    check("t2_reads", 64'(reads_n - r0), 64'd2);
    check("t2_hold", {32'd0, m_tdata}, 64'hD0);
    check("t2_valid", {63'd0, m_tvalid}, 64'd1);
    rdy_r = 1'b1;
    run_until(6, 30, "t2_count");
    check("t2_beat0", 64'(log_q[0]), {31'd0, 1'b0, 32'hD0});
    check("t2_beat1", 64'(log_q[1]), {31'd0, 1'b0, 32'hD1});
    check("t2_beat4", 64'(log_q[4]), {31'd0, 1'b1, 32'hD4});
    check("t2_beat5", 64'(log_q[5]), {31'd0, 1'b0, 32'hD5});

    // Reset with both entries full and the beat index at 3
    rdy_r = 1'b0;
    for (int i = 0; i < 4; i++) src.push_back(32'hE0 + 32'(i));
    repeat (4) step();
    check("t4_pre_valid", {63'd0, m_tvalid}, 64'd1);
    rst_r = 1'b1;
    step();
    check("t4_valid", {63'd0, m_tvalid}, 64'd0);
    rst_r = 1'b0; rdy_r = 1'b1;
    for (int i = 0; i < 4; i++) src.push_back(32'hC0 + 32'(i));
    log_q.delete();
    run_until(6, 30, "t4_count");
    check("t4_beat0", 64'(log_q[0]), {31'd0, 1'b0, 32'hE2});
    check("t4_beat4", 64'(log_q[4]), {31'd0, 1'b1, 32'hC2});
    check("t4_beat5", 64'(log_q[5]), {31'd0, 1'b0, 32'hC3});

    // Random back-pressure and FIFO availability, 1000 words
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    log_q.delete();
    for (int i = 0; i < 1000; i++) src.push_back($urandom);
    begin
      int k = 0;
      while (log_q.size() < 1000 && k < 20000) begin
        rdy_r   = 1'($urandom % 2);
        avail_r = ($urandom % 4) != 0;
        step();
        k++;
      end
    end
    check("t3_count", 64'(log_q.size()), 64'd1000);
    lasts = 0;
    foreach (log_q[i]) if (log_q[i].last) lasts++;
    check("t3_lasts", 64'(lasts), 64'd200);
    check("t3_last_idx4", {63'd0, log_q[4].last}, 64'd1);
    check("t3_last_idx999", {63'd0, log_q[999].last}, 64'd1);
    rdy_r = 1'b1; avail_r = 1'b1;

    // PKT_LEN=1 instance: three words, every one is last
    n1_left = 3;
    repeat (8) step();
    check("t5_lasts", 64'(last1_n), 64'd3);
    check("t5_pkt_done", 64'(pd1_n), 64'd3);

`ifdef FIFO_RD_STATS_EN
    // Handshake counter wraps at 16
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    check("t6_cnt_reset", 64'(word_cnt), 64'd0);
    for (int i = 0; i < 17; i++) src.push_back(32'hF0 + 32'(i));
    log_q.delete();
    run_until(17, 60, "t6_count");
    step();
    check("t6_cnt_wrap", 64'(word_cnt), 64'd1);
    rst_r = 1'b1;
    step();
    check("t6_cnt_clear", 64'(word_cnt), 64'd0);
    rst_r = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
